// File: rtl/prof_pkg.sv
// Shared widths, FSM state type and the record layout used by the ap_ctrl profiler.
package prof_pkg;

  localparam int PROF_TS_W  = 32;
  localparam int PROF_CNT_W = 16;
  localparam int PROF_DEPTH = 4;
  localparam int PROF_REC_W = PROF_TS_W + 3 * PROF_CNT_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } prof_state_e;

  typedef struct packed {
    logic [PROF_TS_W-1:0]  start_ts;
    logic [PROF_CNT_W-1:0] latency;
    logic [PROF_CNT_W-1:0] iters;
    logic [PROF_CNT_W-1:0] stalls;
  } prof_rec_t;

  // start_ts lands in the MSBs so records sort by start time when read as integers.
  function automatic logic [PROF_REC_W-1:0] pack_rec(input prof_rec_t r);
    return {r.start_ts, r.latency, r.iters, r.stalls};
  endfunction

endpackage

// File: rtl/prof_rec_fifo.sv
// Synchronous record FIFO: registered storage array, head read straight from storage,
// accepts a push into a full FIFO only when a pop frees a slot in the same cycle.
module prof_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Storage is not reset; gating keeps the head at zero whenever nothing is queued.
  assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (!reset && !clear && do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ap_ctrl_profiler.sv
// Profiles ap_ctrl_hs transactions into {start_ts, latency, iters, stalls} records.
// Stall counting is built only when PROFILER_STALL_CNT_EN is defined.
module ap_ctrl_profiler
  import prof_pkg::*;
#(
  parameter int TS_W  = PROF_TS_W,
  parameter int CNT_W = PROF_CNT_W,
  parameter int DEPTH = PROF_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ap_start,
  input  logic                    ap_done,
  input  logic                    iter_end,
  input  logic                    loop_stall,
  input  logic                    clear,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [TS_W+3*CNT_W-1:0] rec_data,
  output logic                    busy,
  output logic [7:0]              drop_cnt
);

  localparam int REC_W = TS_W + 3 * CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  prof_state_e      state_reg, state_next;
  logic             reload_reg, reload_next;
  logic [TS_W-1:0]  ts_reg;
  logic [TS_W-1:0]  start_ts_reg;
  logic [CNT_W-1:0] lat_reg;
  logic [CNT_W-1:0] iters_reg;
  logic [7:0]       drop_cnt_reg;

  logic             start_cycle;
  logic             done_cycle;
  logic [TS_W-1:0]  cur_ts;
  logic [CNT_W-1:0] cur_lat;
  logic [CNT_W-1:0] cur_iters;
  logic [CNT_W-1:0] cur_stalls;
  logic [REC_W-1:0] push_data;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  // reload_reg marks the cycle after a back-to-back done as a fresh start cycle.
  always_comb begin
    state_next  = state_reg;
    reload_next = 1'b0;
    start_cycle = 1'b0;
    done_cycle  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ap_start) begin
          start_cycle = 1'b1;
          if (ap_done) done_cycle = 1'b1;
          else         state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        start_cycle = reload_reg;
        if (ap_done) begin
          done_cycle = 1'b1;
          if (ap_start) reload_next = 1'b1;
          else          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (clear) begin
      state_next  = ST_IDLE;
      reload_next = 1'b0;
    end
  end

  // Counter values including this cycle's increments; these are what a done cycle records.
  assign cur_ts    = start_cycle ? ts_reg : start_ts_reg;
  assign cur_lat   = start_cycle ? CNT_W'(1) : sat_inc(lat_reg, 1'b1);
  assign cur_iters = start_cycle ? CNT_W'(iter_end) : sat_inc(iters_reg, iter_end);

`ifdef PROFILER_STALL_CNT_EN
  logic [CNT_W-1:0] stalls_reg;

  assign cur_stalls = start_cycle ? CNT_W'(loop_stall) : sat_inc(stalls_reg, loop_stall);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      stalls_reg <= '0;
    end else if (start_cycle || state_reg == ST_RUN) begin
      stalls_reg <= cur_stalls;
    end
  end
`else
  logic unused_loop_stall;

  assign unused_loop_stall = loop_stall;
  assign cur_stalls        = '0;
`endif

  generate
    if (TS_W == PROF_TS_W && CNT_W == PROF_CNT_W) begin : g_pkg_pack
      prof_rec_t rec;
      assign rec       = '{start_ts: cur_ts, latency: cur_lat, iters: cur_iters, stalls: cur_stalls};
      assign push_data = pack_rec(rec);
    end else begin : g_cat_pack
      assign push_data = {cur_ts, cur_lat, cur_iters, cur_stalls};
    end
  endgenerate

  assign push = done_cycle && !clear;
  assign drop = push && fifo_full && !rec_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      reload_reg   <= 1'b0;
      ts_reg       <= '0;
      start_ts_reg <= '0;
      lat_reg      <= '0;
      iters_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      ts_reg     <= ts_reg + TS_W'(1);
      state_reg  <= state_next;
      reload_reg <= reload_next;
      if (clear) begin
        start_ts_reg <= '0;
        lat_reg      <= '0;
        iters_reg    <= '0;
        drop_cnt_reg <= '0;
      end else begin
        if (start_cycle || state_reg == ST_RUN) begin
          start_ts_reg <= cur_ts;
          lat_reg      <= cur_lat;
          iters_reg    <= cur_iters;
        end
        if (drop && drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  prof_rec_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .push     (push),
    .push_data(push_data),
    .full     (fifo_full),
    .pop      (rec_ready),
    .empty    (fifo_empty),
    .pop_data (rec_data)
  );

  assign rec_valid = !fifo_empty;
  assign busy      = (state_reg == ST_RUN);
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// Directed bench for ap_ctrl_profiler: a transaction table plus hand sequences for
// back-to-back, full FIFO, clear and reset; stall expectations follow PROFILER_STALL_CNT_EN.
module tb_ap_ctrl_profiler;

`ifdef PROFILER_STALL_CNT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0, ap_done = 1'b0, iter_end = 1'b0, loop_stall = 1'b0;
  logic        clear = 1'b0, rec_ready = 1'b0;
  logic        rec_valid, busy;
  logic [79:0] rec_data;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  ap_ctrl_profiler dut (
    .clock     (clock),
    .reset     (reset),
    .ap_start  (ap_start),
    .ap_done   (ap_done),
    .iter_end  (iter_end),
    .loop_stall(loop_stall),
    .clear     (clear),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          start;
    int          len;
    int          n_it;
    int          st_off;
    int          n_st;
    logic [79:0] exp;
  } txn_t;

  txn_t tbl [4];

  function automatic logic [79:0] mk(input int ts, input int lat, input int it, input int st);
    return {32'(ts), 16'(lat), 16'(it), 16'(st)};
  endfunction

  // cyc mirrors the DUT timestamp: it is the index of the cycle now being driven.
  task automatic step();
    @(posedge clock);
    cyc = reset ? 0 : cyc + 1;
    #1;
  endtask

  task automatic wait_until(input int c);
    for (int g = 0; g < 2000 && cyc < c; g++) step();
  endtask

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm, input logic [79:0] exp);
    chk({nm, "_valid"}, 80'(rec_valid), 80'(1));
    chk({nm, "_data"}, rec_data, exp);
    $display("record %s: ts=%0d lat=%0d iters=%0d stalls=%0d", nm,
             rec_data[79:48], rec_data[47:32], rec_data[31:16], rec_data[15:0]);
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  task automatic run_txn(input string nm, input int start, input int len, input int n_it,
                         input int st_off, input int n_st);
    wait_until(start);
    for (int k = 0; k <= len; k++) begin
      ap_start   = (k == 0);
      ap_done    = (k == len);
      iter_end   = (k < n_it);
      loop_stall = (k >= st_off) && (k < st_off + n_st);
      chk({nm, "_busy"}, 80'(busy), 80'(k > 0));
      step();
    end
    ap_start = 1'b0; ap_done = 1'b0; iter_end = 1'b0; loop_stall = 1'b0;
  endtask

  initial begin
    tbl[0] = '{start: 5,  len: 9, n_it: 3, st_off: 0, n_st: 0, exp: mk(5, 10, 3, 0)};
    tbl[1] = '{start: 20, len: 0, n_it: 0, st_off: 0, n_st: 0, exp: mk(20, 1, 0, 0)};
    tbl[2] = '{start: 25, len: 2, n_it: 3, st_off: 1, n_st: 2, exp: mk(25, 3, 3, STALL_ON ? 2 : 0)};
    tbl[3] = '{start: 31, len: 7, n_it: 0, st_off: 2, n_st: 4, exp: mk(31, 8, 0, STALL_ON ? 4 : 0)};

    step(); step();
    reset = 1'b0;
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_valid", 80'(rec_valid), 80'(0));
    chk("rst_data", rec_data, 80'(0));
    chk("rst_drop", 80'(drop_cnt), 80'(0));

    for (int i = 0; i < 4; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i].start, tbl[i].len, tbl[i].n_it,
              tbl[i].st_off, tbl[i].n_st);
      chk($sformatf("tbl%0d_idle", i), 80'(busy), 80'(0));
      pop_chk($sformatf("tbl%0d", i), tbl[i].exp);
      chk($sformatf("tbl%0d_empty", i), 80'(rec_valid), 80'(0));
    end

    // Done without start in IDLE must not produce a record.
    ap_done = 1'b1; step(); ap_done = 1'b0;
    chk("lone_done_valid", 80'(rec_valid), 80'(0));
    chk("lone_done_busy", 80'(busy), 80'(0));

    // Back-to-back: done with start at 50, second transaction 51..55.
    wait_until(45);
    ap_start = 1'b1; step(); ap_start = 1'b0;
    while (cyc < 56) begin
      ap_done  = (cyc == 50) || (cyc == 55);
      ap_start = (cyc == 50);
      chk($sformatf("b2b_busy%0d", cyc), 80'(busy), 80'(1));
      step();
    end
    ap_done = 1'b0; ap_start = 1'b0;
    chk("b2b_idle", 80'(busy), 80'(0));
    pop_chk("b2b_first", mk(45, 6, 0, 0));
    pop_chk("b2b_second", mk(51, 5, 0, 0));
    chk("b2b_empty", 80'(rec_valid), 80'(0));

    // Six one-cycle transactions into a depth-4 FIFO with no consumer.
    for (int i = 0; i < 6; i++) run_txn($sformatf("fill%0d", i), 60 + 2 * i, 0, 0, 0, 0);
    chk("full_drop", 80'(drop_cnt), 80'(2));
    chk("full_head", rec_data, mk(60, 1, 0, 0));
    wait_until(72);
    ap_start = 1'b1; ap_done = 1'b1; rec_ready = 1'b1;
    step();
    ap_start = 1'b0; ap_done = 1'b0; rec_ready = 1'b0;
    chk("pushpop_drop", 80'(drop_cnt), 80'(2));
    pop_chk("drain0", mk(62, 1, 0, 0));
    pop_chk("drain1", mk(64, 1, 0, 0));
    pop_chk("drain2", mk(66, 1, 0, 0));
    pop_chk("drain3", mk(72, 1, 0, 0));
    chk("drain_empty", 80'(rec_valid), 80'(0));

    // Clear mid-transaction with two records queued.
    run_txn("clr_q0", 80, 0, 0, 0, 0);
    run_txn("clr_q1", 82, 0, 0, 0, 0);
    wait_until(84);
    ap_start = 1'b1; iter_end = 1'b1; step(); ap_start = 1'b0; iter_end = 1'b0;
    wait_until(87);
    chk("clr_pre_valid", 80'(rec_valid), 80'(1));
    chk("clr_pre_busy", 80'(busy), 80'(1));
    clear = 1'b1; rec_ready = 1'b1; step(); clear = 1'b0; rec_ready = 1'b0;
    chk("clr_valid", 80'(rec_valid), 80'(0));
    chk("clr_busy", 80'(busy), 80'(0));
    chk("clr_drop", 80'(drop_cnt), 80'(0));
    wait_until(90);
    ap_done = 1'b1; step(); ap_done = 1'b0;
    chk("clr_abort_valid", 80'(rec_valid), 80'(0));
    run_txn("clr_after", 92, 1, 0, 0, 0);
    pop_chk("clr_after", mk(92, 2, 0, 0));

    // Reset mid-transaction with two records queued; ap_start held during reset.
    run_txn("rst_q0", 100, 0, 0, 0, 0);
    run_txn("rst_q1", 102, 0, 0, 0, 0);
    wait_until(104);
    ap_start = 1'b1; step(); ap_start = 1'b0;
    wait_until(107);
    reset = 1'b1; ap_start = 1'b1;
    step(); step();
    reset = 1'b0; ap_start = 1'b0;
    chk("mrst_valid", 80'(rec_valid), 80'(0));
    chk("mrst_busy", 80'(busy), 80'(0));
    chk("mrst_data", rec_data, 80'(0));
    wait_until(2);
    ap_done = 1'b1; step(); ap_done = 1'b0;
    chk("mrst_abort_valid", 80'(rec_valid), 80'(0));
    run_txn("mrst_after", 5, 1, 1, 0, 0);
    pop_chk("mrst_after", mk(5, 2, 1, 0));
    chk("mrst_after_empty", 80'(rec_valid), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_profiler.md
AP_CTRL_PROFILER -- requirements
Module: ap_ctrl_profiler

Interface
REQ-001 Parameter TS_W, default 32, free-running timestamp width.
REQ-002 Parameter CNT_W, default 16, width of latency/iteration/stall counters.
REQ-003 Parameter DEPTH, default 4, record FIFO depth; power of two, at least 2.
REQ-004 clock  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ap_start  in  1  ap_ctrl_hs start of the observed module.
REQ-007 ap_done  in  1  ap_ctrl_hs done pulse of the observed module.
REQ-008 iter_end  in  1  one pulse per completed pipelined-loop iteration (last-stage enable and not blocked).
REQ-009 loop_stall  in  1  pipeline subdone block is asserted.
REQ-010 clear  in  1  synchronous flush of the FIFO and drop state; the timestamp keeps running.
REQ-011 rec_valid  out  1  FIFO head record is valid.
REQ-012 rec_ready  in  1  consumer accepts the head record when rec_valid && rec_ready.
REQ-013 rec_data  out  TS_W+3*CNT_W  packed {start_ts, latency, iters, stalls}, with start_ts in the MSBs.
REQ-014 busy  out  1  a transaction is in progress.
REQ-015 drop_cnt  out  8  count of records dropped because the FIFO was full; saturates at 255.

Function
REQ-016 FSM states: IDLE and RUN.
- IDLE->RUN: on a cycle with ap_start=1.
- RUN->IDLE: on ap_done=1 with ap_start=0.
- RUN->RUN: on ap_done=1 with ap_start=1 (back-to-back transaction).
REQ-017 On the IDLE->RUN transition cycle:
- start_ts is captured from the timestamp.
- latency loads 1.
- iters loads iter_end.
- stalls loads loop_stall.
REQ-018 In RUN, each cycle:
- latency increments by 1.
- iters increments when iter_end=1.
- stalls increments when loop_stall=1.
- All three counters saturate at 2^CNT_W-1.
REQ-019 Latency counts cycles inclusive of the start cycle and the done cycle; ap_start and ap_done high in the same IDLE cycle yields a record with latency 1.
REQ-020 Completion: on the done cycle, one record containing that cycle's counter increments is pushed. Any later iter_end belongs to the next transaction.
REQ-021 Back-to-back: on the done cycle with ap_start=1, counters reload per REQ-017 on the next cycle and start_ts takes the timestamp of that next cycle.
REQ-022 Timestamp: increments every cycle from 0 after reset and wraps modulo 2^TS_W; wrap has no other effect.
REQ-023 FIFO: rec_data is driven from registers; a pushed record is visible on rec_valid the cycle after the push.
REQ-024 Full FIFO:
- Push with no pop in the same cycle: the record is dropped and drop_cnt increments.
- Push with a simultaneous pop: the push is accepted.
REQ-025 Empty FIFO: rec_valid=0; rec_ready is ignored.
REQ-026 clear=1:
- Empties the FIFO and zeroes drop_cnt.
- Forces the FSM to IDLE; any in-flight transaction is discarded.
- Takes priority over a simultaneous push or pop.
REQ-027 busy=1 exactly when the state is RUN.
REQ-028 ap_done in IDLE without ap_start is ignored: no record is pushed.

Reset
REQ-029 Reset drives:
- State to IDLE.
- Timestamp, all counters and drop_cnt to 0.
- FIFO empty, rec_valid=0, busy=0, rec_data=0.
REQ-030 Reset asserted mid-transaction or with FIFO contents discards everything; recording resumes on the first ap_start after reset deasserts.
REQ-031 Reset has priority over clear and over all inputs.

Configuration
REQ-032 Macro PROFILER_STALL_CNT_EN.
- Defined: stalls counts per REQ-018.
- Undefined: the stall counter logic is absent, the stalls field reads 0, and loop_stall is ignored.
- Record width and layout are identical in both builds.

Structure
REQ-033 Package prof_pkg holds:
- The default widths.
- The FSM state enum.
- A record struct typedef with fields start_ts, latency, iters and stalls.
- A packing function.
REQ-034 Sub-module prof_rec_fifo: synchronous FIFO, parameterised on width and DEPTH, with push/full/pop/empty/clear; it contains no profiler logic.

Verification
REQ-035 Reset; ap_start at cycle 5 held 1 cycle; ap_done at cycle 14; iter_end pulses 3 times -> one record {start_ts=5, latency=10, iters=3, stalls=0}; busy is high in cycles 6..14 inclusive.
REQ-036 ap_start and ap_done both high at cycle 20 in IDLE -> record {20, 1, 0, 0}.
REQ-037 Done at cycle 30 with ap_start=1, next done at cycle 35 -> two records; the second has start_ts=31 and latency=5; busy never drops.
REQ-038 rec_ready=0; six transactions, DEPTH=4 -> 4 records held, drop_cnt=2; then full FIFO with push and pop in the same cycle -> push accepted, drop_cnt stays 2.
REQ-039 With PROFILER_STALL_CNT_EN defined, loop_stall high 4 cycles mid-transaction -> stalls=4; without the macro -> stalls=0.
REQ-040 Reset or clear asserted mid-transaction with 2 records queued -> rec_valid=0 next cycle, busy=0, no record produced for the aborted transaction.
